// File: rtl/vga_vram_arbiter_if.sv
// vga_vram_arbiter_if
//   Pixel-writer handshake into the VRAM arbiter.
//   master : the writer (drives wr_req/wr_addr/wr_data, sees ack/err/busy)
//   slave  : the arbiter
//   wr_req  - request; held with addr/data stable until wr_ack
//   wr_addr - framebuffer word address
//   wr_data - pixel value
//   wr_ack  - one-clk completion pulse (written or rejected)
//   wr_err  - with wr_ack when the address is outside the framebuffer
//   wr_busy - a request is latched and not yet acked
interface vga_vram_arbiter_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 3
);
   logic                  wr_req;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ack;
   logic                  wr_err;
   logic                  wr_busy;

   modport master (output wr_req, wr_addr, wr_data,
                   input  wr_ack, wr_err, wr_busy);
   modport slave  (input  wr_req, wr_addr, wr_data,
                   output wr_ack, wr_err, wr_busy);
endinterface

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter
//   Shares one single-port video RAM between VGA scan-out and a pixel writer.
//   Scan-out owns every cycle with enable && display_on (read slot); the
//   writer gets the remaining cycles. Read pixels appear on pix_rgb 2 clk
//   after the address is issued.
// Ports
//   clk, reset_n          pixel clock, async active-low reset
//   enable, hpos, vpos,   timing generator tick / position / visible flag
//   display_on
//   wr (slave modport)    writer handshake (req/addr/data, ack/err/busy)
//   ram_addr/we/wdata     RAM command, combinational from the slot owner
//   ram_rdata             RAM read data, 1-clk latency
//   pix_rgb, pix_valid    fetched pixel to the DAC
//   frame_start           pulse on enable at hpos==0 && vpos==0
// Configuration
//   VRAM_VBLANK_ONLY_EN   when defined, the writer only leaves W_PEND during
//                         vertical blank (tear-free updates).
module vga_vram_arbiter #(
   parameter int HPOS_WIDTH = 10,
   parameter int VPOS_WIDTH = 10,
   parameter int H_DISPLAY  = 640,
   parameter int V_DISPLAY  = 480,
   parameter int SCALE_LOG2 = 2,
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [HPOS_WIDTH-1:0] hpos,
   input  logic [VPOS_WIDTH-1:0] vpos,
   input  logic                  display_on,
   vga_vram_arbiter_if.slave     wr,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [DATA_WIDTH-1:0] pix_rgb,
   output logic                  pix_valid,
   output logic                  frame_start
);
   localparam int FB_W     = H_DISPLAY >> SCALE_LOG2;
   localparam int FB_WORDS = FB_W * (V_DISPLAY >> SCALE_LOG2);

   localparam logic [ADDR_WIDTH-1:0] FB_W_A     = ADDR_WIDTH'(FB_W);
   localparam logic [ADDR_WIDTH-1:0] FB_WORDS_A = ADDR_WIDTH'(FB_WORDS);
   localparam logic [HPOS_WIDTH-1:0] H_LAST     = HPOS_WIDTH'(H_DISPLAY - 1);
   localparam logic [VPOS_WIDTH-1:0] V_LAST     = VPOS_WIDTH'(V_DISPLAY - 1);
   localparam logic [VPOS_WIDTH-1:0] V_VIS      = VPOS_WIDTH'(V_DISPLAY);

   typedef enum logic [1:0] {W_IDLE, W_PEND, W_WR, W_ACK} wstate_e;

   wstate_e               state_q, state_d;
   logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [2:1]            vld_pipe_q, vld_pipe_d;  // [1]=issued last clk, [2]=pixel out
   logic [DATA_WIDTH-1:0] pix_rgb_q, pix_rgb_d;

   logic                  read_slot;
   logic                  wr_free;
   logic                  in_range;
   logic [ADDR_WIDTH-1:0] rd_addr;

   assign read_slot = enable & display_on;
   assign rd_addr   = row_base_q + ADDR_WIDTH'(hpos >> SCALE_LOG2);
   assign in_range  = (wr_addr_q < FB_WORDS_A);

`ifdef VRAM_VBLANK_ONLY_EN
   // Hblank slots are deliberately left unused so a frame never shows a
   // half-updated picture.
   assign wr_free = ~read_slot & (vpos >= V_VIS);
`else
   assign wr_free = ~read_slot;
`endif

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= W_IDLE;
         row_base_q <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         vld_pipe_q <= '0;
         pix_rgb_q  <= '0;
      end else begin
         state_q    <= state_d;
         row_base_q <= row_base_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         vld_pipe_q <= vld_pipe_d;
         pix_rgb_q  <= pix_rgb_d;
      end
   end

   // ---------------- scan-out datapath ----------------
   always_comb begin
      // Row base advances once per 2^SCALE_LOG2 visible lines, at the last
      // visible pixel, and wraps at the end of the visible frame.
      row_base_d = row_base_q;
      if (enable && hpos == H_LAST && vpos < V_VIS) begin
         if (vpos == V_LAST)
            row_base_d = '0;
         else if (&vpos[SCALE_LOG2-1:0])
            row_base_d = row_base_q + FB_W_A;
      end
      vld_pipe_d = {vld_pipe_q[1], read_slot};
      pix_rgb_d  = vld_pipe_q[1] ? ram_rdata : '0;
   end

   assign pix_rgb     = pix_rgb_q;
   assign pix_valid   = vld_pipe_q[2];
   assign frame_start = enable && (hpos == '0) && (vpos == '0);

   // ---------------- write FSM: next state ----------------
   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      unique case (state_q)
         W_IDLE: if (wr.wr_req) begin
            wr_addr_d = wr.wr_addr;
            wr_data_d = wr.wr_data;
            state_d   = W_PEND;
         end
         W_PEND: if (wr_free) state_d = W_WR;
         // Scan-out may reclaim the slot (enable rising); retry next free clk.
         W_WR:   if (!read_slot) state_d = W_ACK;
         W_ACK:  state_d = W_IDLE;
         default: state_d = W_IDLE;
      endcase
   end

   // ---------------- RAM mux and handshake outputs ----------------
   always_comb begin
      ram_addr   = '0;
      ram_we     = 1'b0;
      ram_wdata  = '0;
      wr.wr_busy = (state_q == W_PEND) || (state_q == W_WR);
      wr.wr_ack  = (state_q == W_ACK);
      wr.wr_err  = (state_q == W_ACK) && !in_range;
      if (read_slot) begin
         ram_addr = rd_addr;
      end else if (state_q == W_WR) begin
         ram_addr  = wr_addr_q;
         ram_we    = in_range;   // out-of-range requests complete without touching RAM
         ram_wdata = wr_data_q;
      end
   end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
module tb_vga_vram_arbiter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable, display_on;
   logic [9:0]  hpos, vpos;
   logic [14:0] ram_addr;
   logic        ram_we;
   logic [2:0]  ram_wdata;
   logic [2:0]  ram_rdata = '0;
   logic [2:0]  pix_rgb;
   logic        pix_valid, frame_start;

   vga_vram_arbiter_if #(.ADDR_WIDTH(15), .DATA_WIDTH(3)) wr ();

   vga_vram_arbiter dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .hpos(hpos), .vpos(vpos),
      .display_on(display_on), .wr(wr),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
      .frame_start(frame_start));

   always #5 clk = ~clk;

   // Synchronous single-port RAM, read-before-write.
   logic [2:0] mem [0:32767];
   always @(posedge clk) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] = ram_wdata;
   end

   int checks = 0, errors = 0, cyc = 0;
   int we_cnt = 0, ack_cnt = 0;
   int lw_addr = -1, lw_data = -1, lw_v = -1, lw_disp = -1, lw_cyc = -10;
   int ack_we_addr = -1, la_err = -1;
   bit mon_en = 0;
   bit s1 = 0, s2 = 0;
   int k1 = 0, k2 = 0;
   logic [14:0] obs_addr [int];
   logic [2:0]  obs_rgb  [int];

   typedef struct { int h; int v; int exp_addr; int exp_rgb; } vec_t;
   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Write/ack bookkeeping and the scan-out pipeline model.
   always @(negedge clk) begin
      int key;
      bit slot;
      cyc++;
      slot = enable && display_on;
      key  = int'(vpos) * 1024 + int'(hpos);
      if (ram_we) begin
         we_cnt++;
         lw_addr = int'(ram_addr); lw_data = int'(ram_wdata);
         lw_v = int'(vpos); lw_disp = int'(display_on); lw_cyc = cyc;
         chk("we_in_read_slot", slot, 0);
      end
      if (wr.wr_ack) begin
         ack_cnt++;
         la_err = int'(wr.wr_err);
         ack_we_addr = (lw_cyc == cyc - 1) ? lw_addr : -1;
      end
      if (mon_en) begin
         chk("pix_valid_vs_slot", pix_valid, s2);
         if (s2) obs_rgb[k2] = pix_rgb;
         else    chk("pix_rgb_idle_zero", pix_rgb, 0);
         if (slot) obs_addr[key] = ram_addr;
         s2 = s1; k2 = k1; s1 = slot; k1 = key;
      end else begin
         s1 = 0; s2 = 0;
      end
   end

   task automatic tick(input logic en, input logic disp, input int h, input int v);
      @(posedge clk); #1;
      enable = en; display_on = disp; hpos = h[9:0]; vpos = v[9:0];
      if (wr.wr_ack) wr.wr_req = 1'b0;   // requester drops req in the ack cycle
   endtask

   task automatic wait_ack(input string nm);
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick(0, 0, 0, 500);
         if (wr.wr_ack) got = 1;
      end
      chk({nm, "_ack_seen"}, got, 1);
      @(negedge clk); #1;
   endtask

   // mode 0: only the last visible pixel (keeps row_base stepping),
   // mode 1: full line, mode 2: full line at half enable rate.
   task automatic line(input int v, input int mode);
      if (mode == 0) begin
         tick(1, 1, 639, v);
         tick(1, 0, 640, v);
      end else begin
         for (int h = 0; h < 640; h++) begin
            tick(1, 1, h, v);
`ifndef VRAM_VBLANK_ONLY_EN
            if (v == 3 && h == 0) begin
               wr.wr_req = 1'b1; wr.wr_addr = 15'd300; wr.wr_data = 3'd4;
            end
`endif
            if (v == 10 && h == 100) begin
               wr.wr_req = 1'b1; wr.wr_addr = 15'd42; wr.wr_data = 3'd5;
            end
            if (mode == 2) tick(0, 1, h, v);
         end
         for (int h = 640; h < 656; h++) tick(1, 0, h, v);
      end
   endtask

   initial begin
      int a0, we0, key, got_a, got_p;
      for (int k = 0; k < 32768; k++) mem[k] = 3'(k % 8);
      vecs[0]  = '{3,   0,   0,     0};
      vecs[1]  = '{5,   0,   1,     1};
      vecs[2]  = '{638, 0,   159,   7};
      vecs[3]  = '{639, 3,   159,   7};
      vecs[4]  = '{4,   3,   1,     1};
      vecs[5]  = '{0,   4,   160,   0};
      vecs[6]  = '{4,   4,   161,   1};
      vecs[7]  = '{100, 8,   345,   1};
      vecs[8]  = '{639, 10,  479,   7};
      vecs[9]  = '{639, 477, 19199, 7};
      vecs[10] = '{0,   479, 19040, 0};
      vecs[11] = '{639, 479, 19199, 7};

      // Reset with a request already asserted.
      reset_n = 0; enable = 0; display_on = 0; hpos = 0; vpos = 0;
      wr.wr_req = 1; wr.wr_addr = 15'd7; wr.wr_data = 3'd5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ram",  {ram_addr, ram_we, ram_wdata}, 0);
      chk("rst_pix",  {pix_rgb, pix_valid, frame_start}, 0);
      chk("rst_wr",   {wr.wr_ack, wr.wr_err, wr.wr_busy}, 0);
      @(posedge clk); #1;
      reset_n = 1; vpos = 500; wr.wr_addr = 15'd9; wr.wr_data = 3'd6;
      wait_ack("rst1");
      chk("rst1_wr_addr", lw_addr, 9);
      chk("rst1_wr_data", lw_data, 6);
      chk("rst1_ack_after_we", ack_we_addr, 9);
      chk("rst1_mem9", mem[9], 6);
      chk("rst1_mem7_untouched", mem[7], 7);

      // Reset while a write is pending behind scan-out reads.
      tick(1, 1, 10, 0);
      wr.wr_req = 1; wr.wr_addr = 15'd11; wr.wr_data = 3'd1;
      repeat (3) tick(1, 1, 10, 0);
      @(negedge clk);
      chk("pend_busy", wr.wr_busy, 1);
      chk("pend_no_we", ram_we, 0);
      @(posedge clk); #1;
      reset_n = 0; enable = 0; display_on = 0; vpos = 500;
      wr.wr_addr = 15'd12; wr.wr_data = 3'd2;
      @(negedge clk);
      chk("rst2_wr", {wr.wr_ack, wr.wr_err, wr.wr_busy}, 0);
      chk("rst2_ram", {ram_addr, ram_we}, 0);
      a0 = ack_cnt;
      @(posedge clk); #1; reset_n = 1;
      wait_ack("rst2");
      chk("rst2_wr_addr", lw_addr, 12);
      chk("rst2_mem11_dropped", mem[11], 3);
      chk("rst2_mem12", mem[12], 2);
      chk("rst2_one_ack", ack_cnt - a0, 1);

      // One frame of scan-out with writes mixed in.
      repeat (3) tick(0, 0, 0, 500);
      mon_en = 1;
      a0 = ack_cnt;
      for (int v = 0; v < 480; v++)
         line(v, (v == 8) ? 2 : (v == 0 || v == 3 || v == 4 || v == 10 || v == 479) ? 1 : 0);
      for (int v = 480; v < 483; v++)
         for (int h = 0; h < 16; h++) tick(1, 0, h, v);
      tick(1, 1, 0, 0);
      @(negedge clk);
      chk("frame_start_pulse", frame_start, 1);
      chk("row_base_wrapped", ram_addr, 0);
      tick(1, 1, 4, 0);
      @(negedge clk);
      chk("frame_start_low", frame_start, 0);
      chk("row0_word1_addr", ram_addr, 1);
      repeat (3) tick(0, 0, 0, 500);
      mon_en = 0;

      for (int i = 0; i < 12; i++) begin
         key   = vecs[i].v * 1024 + vecs[i].h;
         got_a = obs_addr.exists(key) ? int'(obs_addr[key]) : -1;
         got_p = obs_rgb.exists(key)  ? int'(obs_rgb[key])  : -1;
         chk($sformatf("scan_addr h%0d v%0d", vecs[i].h, vecs[i].v), got_a, vecs[i].exp_addr);
         chk($sformatf("scan_rgb h%0d v%0d",  vecs[i].h, vecs[i].v), got_p, vecs[i].exp_rgb);
      end

      // Line-10 request: write lands outside the visible area, ack 1 clk later.
      chk("hb_wr_addr", lw_addr, 42);
      chk("hb_wr_data", lw_data, 5);
      chk("hb_wr_not_visible", lw_disp, 0);
      chk("hb_ack_after_we", ack_we_addr, 42);
      chk("hb_mem42", mem[42], 5);
`ifdef VRAM_VBLANK_ONLY_EN
      chk("hb_wr_in_vblank", lw_v >= 480, 1);
      chk("frame_ack_count", ack_cnt - a0, 1);
`else
      chk("hb_wr_line10", lw_v, 10);
      chk("frame_ack_count", ack_cnt - a0, 2);
`endif

      // Out-of-range write is rejected; last valid word is accepted.
      a0 = ack_cnt; we0 = we_cnt;
      wr.wr_req = 1; wr.wr_addr = 15'd19200; wr.wr_data = 3'd3;
      wait_ack("range");
      chk("range_err", la_err, 1);
      repeat (3) tick(0, 0, 0, 500);
      chk("range_no_we", we_cnt - we0, 0);
      chk("range_one_ack", ack_cnt - a0, 1);
      we0 = we_cnt;
      wr.wr_req = 1; wr.wr_addr = 15'd19199; wr.wr_data = 3'd0;
      wait_ack("last_word");
      chk("last_word_err", la_err, 0);
      chk("last_word_we", we_cnt - we0, 1);
      chk("last_word_mem", mem[19199], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
